// File: rtl/io_port_hub.sv
// I/O bus responder: per-port input holding registers,
// output registers with write strobes, and arrival interrupt.
module io_port_hub #(
  parameter int                NUBITS = 16,
  parameter int                NUIOIN = 2,
  parameter int                NUIOOU = 2,
  parameter logic [NUIOIN-1:0] ITRMSK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUBITS-1:0]          io_out,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic                       out_en,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  input  logic                       req_in,
  output logic [NUBITS-1:0]          io_in,
  output logic                       itr,
  input  logic [NUIOIN*NUBITS-1:0]   in_data,
  input  logic [NUIOIN-1:0]          in_valid,
  output logic [NUIOIN-1:0]          in_ready,
  output logic [NUIOOU*NUBITS-1:0]   out_data,
  output logic [NUIOOU-1:0]          out_stb,
  output logic                       underflow
);

  localparam int AIW = $clog2(NUIOIN);
  localparam int AOW = $clog2(NUIOOU);

  logic [NUIOIN-1:0][NUBITS-1:0] hold_q, hold_d;
  logic [NUIOIN-1:0]             full_q, full_d;
  logic [NUBITS-1:0]             io_in_q, io_in_d;
  logic                          itr_q, itr_d;
  logic [NUIOOU-1:0][NUBITS-1:0] odat_q, odat_d;
  logic [NUIOOU-1:0]             stb_q, stb_d;
  logic                          unf_q, unf_d;
  logic [NUIOIN-1:0]             cap;
  logic                          hit;

  assign cap = in_valid & ~full_q;

  always_comb begin
    hold_d  = hold_q;
    full_d  = full_q;
    io_in_d = io_in_q;
    odat_d  = odat_q;
    unf_d   = unf_q;
    stb_d   = '0;
    hit     = 1'b0;
    itr_d   = |(cap & ITRMSK);
    for (int k = 0; k < NUIOIN; k++) begin
      if (cap[k]) begin
        hold_d[k] = in_data[k*NUBITS +: NUBITS];
        full_d[k] = 1'b1;
      end
      // A full port never captures, so drain and fill never collide.
      if (req_in && addr_in == AIW'(k) && full_q[k]) begin
        io_in_d   = hold_q[k];
        full_d[k] = 1'b0;
        hit       = 1'b1;
      end
    end
    if (req_in && !hit) begin
      io_in_d = '0;
      unf_d   = 1'b1;
    end
    for (int k = 0; k < NUIOOU; k++) begin
      if (out_en && addr_out == AOW'(k)) begin
        odat_d[k] = io_out;
        stb_d[k]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      full_q  <= '0;
      io_in_q <= '0;
      itr_q   <= 1'b0;
      odat_q  <= '0;
      stb_q   <= '0;
      unf_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      full_q  <= full_d;
      io_in_q <= io_in_d;
      itr_q   <= itr_d;
      odat_q  <= odat_d;
      stb_q   <= stb_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready  = ~full_q;
  assign io_in     = io_in_q;
  assign itr       = itr_q;
  assign out_data  = odat_q;
  assign out_stb   = stb_q;
  assign underflow = unf_q;

endmodule
